sd_result_writer: RTL
=====================

# sd_result_writer

Writes one UUT result record to the SD card as a single 512-byte block through the sdspihost write interface. Sits between the autotest FSM and sdspihost: the FSM pulses `start` with a block address and the UUT result/status, and this block sequences the `w_block`/`w_byte` handshake. It runs byte by byte, pads the block, and reports `done` or `err`. It replaces ad-hoc write sequencing inside the FSM.

## Interface
- `OUTPUT_SIZE`, default 32: UUT result width in bits. Must be a multiple of 8 and ≤ 4088, so that 1 + OUTPUT_SIZE/8 ≤ 512.
- `TIMEOUT_CYCLES`, default 1_000_000: maximum number of cycles any single wait on `spi_busy` may last.
- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request. Sampled only in IDLE.
- `block_addr` in 32: SD block address, captured on `start`.
- `result` in OUTPUT_SIZE: UUT output, captured on `start`.
- `uut_err`, `uut_end` in 1: UUT status flags, captured on `start`.
- `busy` out 1: high from the cycle after an accepted `start` until return to IDLE.
- `done` out 1: one-cycle pulse on completion, whether successful or failed.
- `err` out 1: sticky failure flag. Cleared on the next accepted `start`.
- `spi_busy`, `spi_err` in 1: from sdspihost.
- `spi_block_addr` out 32: held stable while `spi_w_block` is high.
- `spi_data_in` out 8: current byte.
- `spi_w_block` out 1: level, high for the whole block transfer.
- `spi_w_byte` out 1: one-cycle strobe per byte.

## Operation
- Block layout:
  - Byte 0 = {6'b0, uut_err, uut_end}.
  - Bytes 1..OUTPUT_SIZE/8 = result, most significant byte first.
  - Remaining bytes up to 511 = 0x00.
- States:
  - IDLE: on `start`, capture inputs, clear `err`, set byte counter to 0, go to CMD.
  - CMD: drive `spi_w_block`=1. Wait for `spi_busy` to rise, then fall; a `seen_busy` flag tracks this. Then go to SEND.
  - SEND: drive `spi_data_in` = byte[cnt], pulse `spi_w_byte` for exactly one cycle, go to ACK.
  - ACK: wait for `spi_busy` rise, then fall. Then:
    - if cnt == 511, go to FIN;
    - otherwise cnt += 1 and go to SEND.
  - FIN: drop `spi_w_block`. Wait until `spi_busy` is low for one cycle, to cover the card's data-busy period. Pulse `done`, go to IDLE.
  - FAIL: `spi_w_block`=0, `err`=1, pulse `done`, go to IDLE.
- Counter: 9 bits (0..511), no wrap. Reaching 511 always ends the transfer.
- Byte source:
  - cnt == 0 → status byte.
  - 1 ≤ cnt ≤ OUTPUT_SIZE/8 → result byte.
  - Otherwise → 0x00.
- `spi_err` high in any state other than IDLE → FAIL next cycle. No further `spi_w_byte` is issued.
- Watchdog: the counter reloads on every state change. If it reaches TIMEOUT_CYCLES in CMD, ACK or FIN → FAIL.
- `start` while `busy` is high is ignored: no recapture, no effect on the transfer.
- If `spi_err` and a timeout occur in the same cycle, the result is the same single FAIL.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `spi_w_block`=0, `spi_w_byte`=0, `spi_data_in`=0, `spi_block_addr`=0. State = IDLE.
- Reset applied mid-transfer forces all of the above immediately, because reset is asynchronous. No partial-block recovery.
- `start` at cycle t → `busy` and `spi_w_block` high at t+1.
- `spi_data_in` is valid in the same cycle as `spi_w_byte` and is held until the next SEND.
- Minimum of 3 cycles per byte (SEND, busy-high, busy-low), plus sdspihost latency.
- `done` pulses one cycle after the FIN or FAIL condition. `busy` falls in the same cycle as the `done` pulse.

## Structure
- Package `sd_writer_pkg`:
  - `state_t` enum (IDLE, CMD, SEND, ACK, FIN, FAIL);
  - `BLOCK_BYTES`=512;
  - `STATUS_END_BIT`=0, `STATUS_ERR_BIT`=1.
- One sub-module, `result_byte_shifter`:
  - loads {status, result} on `start`;
  - shifts out 8 bits per advance;
  - emits 0x00 once exhausted.
- The FSM, byte counter and watchdog remain in `sd_result_writer`.

## Test plan
- **Nominal write.** OUTPUT_SIZE=32, result=0xDEADBEEF, uut_end=1, uut_err=0, addr=0x0000_0010. Sdspihost model has 2-cycle busy per byte.
  - Expect exactly 512 `spi_w_byte` strobes with bytes 01, DE, AD, BE, EF, then 507×00.
  - `spi_block_addr`=0x10 throughout; one `done`; `err`=0.
- **Start while busy.** Second `start` with result=0x12345678 at byte 50. Expect the block content unchanged and only one `done`.
- **SPI error.** `spi_err` asserted during ACK of byte 100.
  - Expect FAIL next cycle; `spi_w_block`=0; no further strobes.
  - Expect `err`=1 and one `done`.
  - The next `start` clears `err`.
- **Timeout.** TIMEOUT_CYCLES=16, `spi_busy` stuck high in CMD. Expect `err`=1 and `done` 17 cycles after entering CMD, and zero `spi_w_byte` strobes.
- **Reset mid-transfer.** Assert `rst` low asynchronously at byte 200. Expect all outputs 0 within the same cycle. After release, a new `start` writes a full correct block.
- **Back-to-back.** `start` the cycle after `done`, with addr=0x11 and result=0xCAFEF00D, uut_err=1.
  - Expect byte 0=0x03 and a correct second block.
  - Expect no lost or duplicated strobes.

Source files
------------

// File: rtl/sd_writer_pkg.sv
// sd_writer_pkg: shared states, block constants and status-byte packing for the SD result writer
package sd_writer_pkg;
    typedef enum logic [2:0] {IDLE, CMD, SEND, ACK, FIN, FAIL} state_t;
    localparam int BLOCK_BYTES = 512;
    localparam int STATUS_END_BIT = 0;
    localparam int STATUS_ERR_BIT = 1;
    function automatic logic [7:0] status_byte(input logic uut_err, input logic uut_end);
        status_byte = '0;
        status_byte[STATUS_ERR_BIT] = uut_err;
        status_byte[STATUS_END_BIT] = uut_end;
    endfunction
endpackage

// File: rtl/result_byte_shifter.sv
// result_byte_shifter: holds {status, result} and presents it MSB byte first, zero-filling once drained
module result_byte_shifter #(
    parameter int OUTPUT_SIZE = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   advance,
    input  logic [7:0]             status,
    input  logic [OUTPUT_SIZE-1:0] result,
    output logic [7:0]             byte_out
);
    logic [OUTPUT_SIZE+7:0] sr_q, sr_d;
    always_comb sr_d = load ? {status, result} : advance ? {sr_q[OUTPUT_SIZE-1:0], 8'h00} : sr_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sr_q <= '0;
        else sr_q <= sr_d;
    end
    assign byte_out = sr_q[OUTPUT_SIZE+7 -: 8];
endmodule

// File: rtl/sd_result_writer.sv
// sd_result_writer: sequences one 512-byte sdspihost block write carrying a UUT status byte and result
module sd_result_writer
    import sd_writer_pkg::*;
#(
    parameter int OUTPUT_SIZE    = 32,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [31:0]            block_addr,
    input  logic [OUTPUT_SIZE-1:0] result,
    input  logic                   uut_err,
    input  logic                   uut_end,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    input  logic                   spi_busy,
    input  logic                   spi_err,
    output logic [31:0]            spi_block_addr,
    output logic [7:0]             spi_data_in,
    output logic                   spi_w_block,
    output logic                   spi_w_byte
);
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    state_t state_q, state_d;
    logic [8:0] cnt_q, cnt_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic [31:0] addr_q, addr_d;
    logic seen_q, seen_d, err_q, err_d, done_q, done_d;
    logic accept, waiting, timeout, advance;
    assign accept  = state_q == IDLE && start;
    assign waiting = state_q inside {CMD, ACK, FIN};
    assign timeout = waiting && wd_q == WDW'(TIMEOUT_CYCLES - 1);
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        advance = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = CMD;
                cnt_d   = '0;
            end
            CMD:  if (seen_q && !spi_busy) state_d = SEND;
            SEND: state_d = ACK;
            ACK:  if (seen_q && !spi_busy) begin
                if (cnt_q == 9'(BLOCK_BYTES - 1)) state_d = FIN;
                else begin
                    state_d = SEND;
                    cnt_d   = cnt_q + 9'd1;
                    advance = 1'b1;
                end
            end
            FIN:  if (!spi_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // error and timeout share one exit so a coincidence still yields a single FAIL
        if (state_q != IDLE && state_q != FAIL && (spi_err || timeout)) begin
            state_d = FAIL;
            advance = 1'b0;
        end
        seen_d = state_d != state_q ? 1'b0 : seen_q | spi_busy;
        wd_d   = (state_d != state_q || !waiting) ? '0 : wd_q + WDW'(1);
        done_d = state_d == IDLE && (state_q == FIN || state_q == FAIL);
        err_d  = accept ? 1'b0 : state_q == FAIL ? 1'b1 : err_q;
        addr_d = accept ? block_addr : addr_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wd_q    <= '0;
            addr_q  <= '0;
            seen_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
            addr_q  <= addr_d;
            seen_q  <= seen_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end
    result_byte_shifter #(.OUTPUT_SIZE(OUTPUT_SIZE)) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .advance  (advance),
        .status   (status_byte(uut_err, uut_end)),
        .result   (result),
        .byte_out (spi_data_in)
    );
    assign busy           = state_q != IDLE;
    assign done           = done_q;
    assign err            = err_q;
    assign spi_block_addr = addr_q;
    assign spi_w_block    = state_q inside {CMD, SEND, ACK};
    assign spi_w_byte     = state_q == SEND;
endmodule
